dec_frame_accumulator: RTL and testbench
========================================

# dec_frame_accumulator

Downstream stage of the clock divider. It consumes the divider's `dec_clk` output as a synchronous enable rather than as a clock. It sums the input samples that arrive within each `dec_clk` period into one decimated frame with a sample count and a saturation flag. Finished frames are queued in a small show-ahead FIFO and presented on a valid/ready output port.

## Interface
Parameters:
- `DATA_W`, 16: signed input sample width.
- `ACC_W`, 24: signed accumulator and output width; must be ≥ `DATA_W`.
- `FIFO_DEPTH`, 4: number of output frame entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; same clock as the clock divider.
- `rst`  in  1  reset; synchronous, active-high.
- `dec_clk`  in  1  decimation clock from the divider, sampled as data on `clk`.
- `din`  in  `DATA_W`  signed sample.
- `din_valid`  in  1  `din` is valid this cycle.
- `dout`  out  `ACC_W`  signed frame sum.
- `dout_count`  out  7  number of samples in the frame; saturates at 127.
- `dout_sat`  out  1  accumulator saturated during this frame.
- `dout_valid`  out  1  the head FIFO entry is valid.
- `dout_ready`  in  1  consumer accepts the head entry.
- `overflow`  out  1  sticky flag: a frame was dropped because the FIFO was full.
- `clear_ovf`  in  1  clears `overflow`.

## Operation
- Edge detect:
  - `dec_q` is `dec_clk` registered on `clk`.
  - `edge = dec_clk & ~dec_q`.
  - Falling edges are ignored.
- States:
  - `IDLE`, entered on reset: no accumulation. On `edge`, go to `RUN` with the accumulator, count and saturation flag cleared. No frame is emitted; the first partial period is discarded.
  - `RUN`: each cycle with `din_valid`, `acc <= sat(acc + sext(din))` and `cnt <= min(cnt+1, 127)`.
    - If the sum exceeds the signed `ACC_W` range, clamp to max or min and set `sat_f`.
    - On `edge`, the closing frame includes `din` of that same cycle if `din_valid`.
    - The frame {acc', cnt', sat_f'} is pushed to the FIFO.
    - `acc`, `cnt` and `sat_f` restart at 0 in the next cycle. Restarting on the edge cycle is not allowed, because the edge-cycle sample belongs to the closing frame.
  - No transition out of `RUN` except via `rst`.
- An edge with zero valid samples pushes a frame with `dout=0`, `dout_count=0`, `dout_sat=0`.
- FIFO push:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the frame is dropped, `overflow` is set, and FIFO contents are unchanged.
- FIFO pop: occurs when `dout_valid & dout_ready`.
- Output fields are taken from the head entry. They are held stable while `dout_valid & ~dout_ready`.
- `overflow`:
  - Set takes priority over `clear_ovf` in the same cycle.
  - Otherwise `clear_ovf` clears it.
- Reset mid-frame: the accumulator and FIFO are emptied, the state returns to `IDLE`, and `overflow` is cleared. The next rising `dec_clk` edge re-arms only; it does not emit a frame.

## Timing
- Reset values: `dout`=0, `dout_count`=0, `dout_sat`=0, `dout_valid`=0, `overflow`=0, `dec_q`=0, state `IDLE`.
- Edge latency:
  - `edge` is asserted in cycle N when `dec_clk` is 1 at N and was 0 at N−1.
  - The pushed frame is visible with `dout_valid`=1 in cycle N+1 (FIFO empty case).
- Samples are counted in the new frame starting with cycle N+1.
- Pop latency: after a pop in cycle M, the next entry (if any) is on `dout` in cycle M+1.
- With the FIFO full, push and pop in the same cycle: both take effect; occupancy is unchanged; `overflow` is not set.
- Throughput: one push and one pop per cycle maximum. An edge can occur at most every 2 cycles, because it is a level toggle from the divider.

## Test plan
- **First-edge discard:**
  - Stimulus: reset, then `din_valid`=1 with `din`=1 for 3 cycles before the first rising `dec_clk`, then 4 cycles of `din`=1 before the second rising edge, with the edge cycle also valid.
  - Required response: no frame after the first edge. After the second edge, `dout`=5, `dout_count`=5, `dout_sat`=0, and `dout_valid` at edge+1.
- **Signed sum and empty frame:**
  - Stimulus: samples −3, +10, −20 within one period, then a period with `din_valid`=0.
  - Required response: frames {−13, 3, 0} and {0, 0, 0}.
- **Saturation:**
  - Stimulus: `ACC_W`=17, `DATA_W`=16, ten samples of 0x7FFF in one period.
  - Required response: `dout`=65535, `dout_count`=10, `dout_sat`=1. The next frame has `dout_sat`=0.
- **Backpressure and overflow:**
  - Stimulus: `dout_ready`=0 for 6 frames (`FIFO_DEPTH`=4).
  - Required response: the first 4 frames are retained in order; `overflow` rises on the 5th edge. With `clear_ovf` and a new overflow in the same cycle, `overflow` stays 1. With `dout_ready`=1, the 4 frames drain one per cycle.
- **Full FIFO, simultaneous push/pop:**
  - Stimulus: FIFO full, `dout_ready`=1 on the edge cycle.
  - Required response: head popped, new frame accepted, `overflow` stays 0.
- **Reset mid-operation:**
  - Stimulus: assert `rst` for 1 cycle with 2 frames queued and a partial frame accumulating.
  - Required response: `dout_valid`=0 the next cycle. The next rising edge emits nothing; the following edge emits a frame containing only post-rearm samples.

Source files
------------

// File: rtl/dec_frame_accumulator.sv
// -----------------------------------------------------------------------------
// dec_frame_accumulator
//
// Decimating frame accumulator that sits behind the clock divider. The
// divider's dec_clk is treated as a level sampled on clk; each rising level
// transition closes the frame being summed and opens a new one. A frame is the
// saturating signed sum of all valid samples in one dec_clk period, plus a
// sample count (saturating at 127) and a sticky "accumulator clamped" flag.
// Finished frames go into a small show-ahead FIFO whose head drives the output
// port.
//
// Ports
//   clk         system clock (same clock as the divider)
//   rst         synchronous, active-high reset
//   dec_clk     decimation clock, sampled as data
//   din         signed input sample (DATA_W)
//   din_valid   din carries a sample this cycle
//   dout        signed frame sum of the FIFO head entry (ACC_W)
//   dout_count  number of samples in the head frame (saturates at 127)
//   dout_sat    head frame had its accumulator clamped
//   dout_valid  FIFO head entry is valid
//   dout_ready  consumer accepts the head entry
//   overflow    sticky: a finished frame was dropped because the FIFO was full
//   clear_ovf   clears overflow (a same-cycle drop wins)
//   dbg_state   current accumulator FSM state (0 = IDLE, 1 = RUN)
//
// Output handshake: a transfer happens in every cycle where dout_valid and
// dout_ready are both high at the rising clk edge. While dout_valid is high
// and dout_ready is low the head entry, and therefore dout/dout_count/dout_sat,
// does not change. dout_valid never depends combinationally on dout_ready.
// -----------------------------------------------------------------------------
module dec_frame_accumulator #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_clk,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic signed [ACC_W-1:0]  dout,
    output logic [6:0]               dout_count,
    output logic                     dout_sat,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     overflow,
    input  logic                     clear_ovf,
    output logic                     dbg_state
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FRAME_W = ACC_W + 8;  // {sum, count[6:0], sat}

    localparam logic [ACC_W:0] SUM_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W:0] SUM_MIN = {2'b11, {(ACC_W-1){1'b0}}};
    localparam logic [6:0]     CNT_MAX = 7'd127;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    // -------------------------------------------------------------------------
    // dec_clk rising-level detect
    // -------------------------------------------------------------------------
    logic dec_q;
    logic edge_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q <= 1'b0;
        end else begin
            dec_q <= dec_clk;
        end
    end

    assign edge_det = dec_clk & ~dec_q;

    // -------------------------------------------------------------------------
    // Accumulator datapath
    // -------------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc;
    logic [6:0]              cnt;
    logic                    sat_f;

    logic [ACC_W:0]          sum_wide;
    logic                    sum_ovf;
    logic [ACC_W-1:0]        sum_clamped;

    // Values after folding in this cycle's sample; on an edge cycle these are
    // the closing frame, since the edge-cycle sample belongs to it.
    logic [ACC_W-1:0]        acc_upd;
    logic [6:0]              cnt_upd;
    logic                    sat_upd;

    // One guard bit is enough: a DATA_W sample added to an ACC_W value with
    // ACC_W >= DATA_W can leave the ACC_W range by at most one bit.
    assign sum_wide = {acc[ACC_W-1], acc}
                    + {{(ACC_W+1-DATA_W){din[DATA_W-1]}}, din};
    assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        sum_clamped = sum_wide[ACC_W-1:0];
        if (sum_ovf) begin
            // The guard bit carries the true sign of the unclamped sum.
            sum_clamped = sum_wide[ACC_W] ? SUM_MIN[ACC_W-1:0] : SUM_MAX[ACC_W-1:0];
        end
    end

    always_comb begin
        acc_upd = acc;
        cnt_upd = cnt;
        sat_upd = sat_f;
        if (din_valid) begin
            acc_upd = sum_clamped;
            sat_upd = sat_f | sum_ovf;
            if (cnt != CNT_MAX) begin
                cnt_upd = cnt + 7'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: IDLE waits for the first edge (the partial period before it is
    // discarded); RUN accumulates and emits one frame per edge.
    // -------------------------------------------------------------------------
    logic [ACC_W-1:0] acc_next;
    logic [6:0]       cnt_next;
    logic             sat_next;
    logic             frame_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat_f;
        frame_push = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    state_next = RUN;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end
            end
            RUN: begin
                if (edge_det) begin
                    frame_push = 1'b1;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                end else begin
                    acc_next   = acc_upd;
                    cnt_next   = cnt_upd;
                    sat_next   = sat_upd;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            sat_f <= 1'b0;
        end else begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            sat_f <= sat_next;
        end
    end

    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Output FIFO (show-ahead)
    // -------------------------------------------------------------------------
    logic [FRAME_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     occ;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push_ok;
    logic               push_drop;
    logic [FRAME_W-1:0] frame_data;
    logic [FRAME_W-1:0] head;

    assign frame_data = {acc_upd, cnt_upd, sat_upd};
    assign fifo_full  = (occ == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (occ == '0);
    assign pop        = dout_valid & dout_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok    = frame_push & (~fifo_full | pop);
    assign push_drop  = frame_push & ~push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= frame_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Head storage is not reset, so the fields are forced to zero while the
    // FIFO is empty to keep the outputs defined after reset.
    assign head       = mem[rd_ptr];
    assign dout_valid = ~fifo_empty;
    assign dout       = fifo_empty ? '0 : $signed(head[FRAME_W-1 -: ACC_W]);
    assign dout_count = fifo_empty ? '0 : head[7:1];
    assign dout_sat   = fifo_empty ? 1'b0 : head[0];

endmodule

// File: tb/tb_dec_frame_accumulator.sv
// -----------------------------------------------------------------------------
// tb_dec_frame_accumulator
//
// Self-checking bench for dec_frame_accumulator (DATA_W=16, ACC_W=17,
// FIFO_DEPTH=4). A frame-level reference model (running signed sum with
// clamping, capped sample count, queue of finished frames, sticky overflow)
// advances once per clock from the same inputs driven to the DUT. Each test
// task compares the DUT outputs against the model and/or hand-derived
// constants.
// -----------------------------------------------------------------------------
module tb_dec_frame_accumulator;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 17;
    localparam int DEPTH  = 4;
    localparam int FW     = ACC_W + 8;
    localparam int OW     = FW + 2;
    localparam longint SMAX = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (ACC_W-1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     dec_clk;
    logic signed [DATA_W-1:0] din;
    logic                     din_valid;
    logic signed [ACC_W-1:0]  dout;
    logic [6:0]               dout_count;
    logic                     dout_sat;
    logic                     dout_valid;
    logic                     dout_ready;
    logic                     overflow;
    logic                     clear_ovf;
    logic                     dbg_state;

    dec_frame_accumulator #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_clk   (dec_clk),
        .din       (din),
        .din_valid (din_valid),
        .dout      (dout),
        .dout_count(dout_count),
        .dout_sat  (dout_sat),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [FW-1:0] exp_q[$];   // finished frames {sum, count, sat}, head first
    bit     m_run;
    bit     m_dq;
    bit     m_ovf;
    bit     m_sat;
    longint m_sum;
    int     m_cnt;

    function automatic logic [OW-1:0] pk(bit v, longint d, int c, bit s, bit o);
        return {v, ACC_W'(d), 7'(c), s, o};
    endfunction

    function automatic logic [OW-1:0] exp_obs();
        if (exp_q.size() > 0) return {1'b1, exp_q[0], m_ovf};
        return {1'b0, {FW{1'b0}}, m_ovf};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {dout_valid, dout_valid ? {dout, dout_count, dout_sat} : {FW{1'b0}}, overflow};
    endfunction

    // Advance the model with the inputs currently applied, then let the DUT
    // take the same clock edge and settle.
    task automatic tick();
        bit e;
        bit pop;
        bit push;
        logic [FW-1:0] f;
        push = 1'b0;
        f = '0;
        if (rst) begin
            m_run = 0; m_dq = 0; m_ovf = 0; m_sat = 0; m_sum = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            e    = dec_clk && !m_dq;
            m_dq = dec_clk;
            pop  = (exp_q.size() > 0) && dout_ready;
            if (m_run) begin
                if (din_valid) begin
                    m_sum = m_sum + longint'(din);
                    if (m_sum > SMAX) begin m_sum = SMAX; m_sat = 1; end
                    if (m_sum < SMIN) begin m_sum = SMIN; m_sat = 1; end
                    if (m_cnt < 127) m_cnt = m_cnt + 1;
                end
                if (e) begin
                    f = {ACC_W'(m_sum), 7'(m_cnt), m_sat};
                    push = 1'b1;
                    m_sum = 0; m_cnt = 0; m_sat = 0;
                end
            end else if (e) begin
                m_run = 1; m_sum = 0; m_cnt = 0; m_sat = 0;
            end
            if (pop) void'(exp_q.pop_front());
            if (push && exp_q.size() < DEPTH) begin
                exp_q.push_back(f);
                push = 1'b0;
            end
            if (push) m_ovf = 1;
            else if (clear_ovf) m_ovf = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc(bit dec, bit v, int d);
        dec_clk   = dec;
        din_valid = v;
        din       = DATA_W'(d);
        tick();
    endtask

    task automatic do_reset();
        rst = 1; dec_clk = 0; din_valid = 0; din = '0; dout_ready = 0; clear_ovf = 0;
        tick();
        tick();
        rst = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL reset_outputs: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
        total++;
        if (dbg_state !== 1'b0) begin
            bad++; $display("FAIL reset_state: got %b want 0", dbg_state);
        end
    endtask

    task automatic test_first_edge();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 1);
        cyc(1, 1, 1);
        total++;
        if (obs() !== pk(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL first_edge_discard: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
        end
        total++;
        if (dbg_state !== 1'b1) begin
            bad++; $display("FAIL first_edge_run: got %b want 1", dbg_state);
        end
        cyc(1, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 1, 1);
        cyc(1, 1, 1);
        total++;
        if (obs() !== pk(1, 5, 5, 0, 0)) begin
            bad++; $display("FAIL first_frame: got %h want %h", obs(), pk(1, 5, 5, 0, 0));
        end
        dout_ready = 1; cyc(1, 0, 0); dout_ready = 0;
        total++;
        if (obs() !== exp_obs() || dout_valid !== 1'b0) begin
            bad++; $display("FAIL first_pop: got %h want %h", obs(), exp_obs());
        end
    endtask

    task automatic test_signed_empty();
        cyc(0, 1, -3); cyc(0, 1, 10); cyc(0, 1, -20); cyc(1, 0, 0);
        cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
        total++;
        if (obs() !== pk(1, -13, 3, 0, 0)) begin
            bad++; $display("FAIL signed_frame: got %h want %h", obs(), pk(1, -13, 3, 0, 0));
        end
        dout_ready = 1; cyc(1, 0, 0);
        total++;
        if (obs() !== pk(1, 0, 0, 0, 0)) begin
            bad++; $display("FAIL empty_frame: got %h want %h", obs(), pk(1, 0, 0, 0, 0));
        end
        cyc(1, 0, 0); dout_ready = 0;
        total++;
        if (obs() !== exp_obs()) begin
            bad++; $display("FAIL signed_drain: got %h want %h", obs(), exp_obs());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 10; i++) cyc(0, 1, 32'h7FFF);
        cyc(1, 0, 0);
        total++;
        if (obs() !== pk(1, 65535, 10, 1, 0)) begin
            bad++; $display("FAIL sat_frame: got %h want %h", obs(), pk(1, 65535, 10, 1, 0));
        end
        cyc(0, 1, 4); cyc(0, 1, -1); cyc(1, 0, 0);
        dout_ready = 1; cyc(1, 0, 0);
        total++;
        if (obs() !== pk(1, 3, 2, 0, 0)) begin
            bad++; $display("FAIL after_sat_frame: got %h want %h", obs(), pk(1, 3, 2, 0, 0));
        end
        cyc(1, 0, 0); dout_ready = 0;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL sat_drain: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 140; i++) cyc(0, 1, 0);
        cyc(1, 1, 0);
        total++;
        if (obs() !== pk(1, 0, 127, 0, 0)) begin
            bad++; $display("FAIL count_sat: got %h want %h", obs(), pk(1, 0, 127, 0, 0));
        end
        dout_ready = 1; cyc(1, 0, 0); dout_ready = 0;
    endtask

    task automatic test_backpressure();
        dout_ready = 0;
        for (int f = 1; f <= 6; f++) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                cyc(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 200)) - 100);
            clear_ovf = (f == 6);
            cyc(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 200)) - 100);
            clear_ovf = 0;
            total++;
            if (overflow !== (f >= 5) || obs() !== exp_obs()) begin
                bad++; $display("FAIL bp_edge%0d: got %h want %h ovf_req=%0d", f, obs(), exp_obs(), f >= 5);
            end
        end
        clear_ovf = 1; cyc(1, 0, 0); clear_ovf = 0;
        total++;
        if (overflow !== 1'b0) begin
            bad++; $display("FAIL bp_clear: got %b want 0", overflow);
        end
        dout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (dout_valid !== 1'b1 || obs() !== exp_obs()) begin
                bad++; $display("FAIL bp_drain%0d: got %h want %h", i, obs(), exp_obs());
            end
            cyc(1, 0, 0);
        end
        dout_ready = 0;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL bp_empty: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_full_push_pop();
        int vals[4];
        vals = '{4, 6, 8, 14};
        dout_ready = 0;
        for (int f = 0; f < 4; f++) begin
            cyc(0, 1, f + 1); cyc(0, 1, f + 1); cyc(1, 0, 0);
        end
        total++;
        if (obs() !== pk(1, 2, 2, 0, 0)) begin
            bad++; $display("FAIL full_head: got %h want %h", obs(), pk(1, 2, 2, 0, 0));
        end
        cyc(0, 1, 7);
        dout_ready = 1; cyc(1, 1, 7); dout_ready = 0;
        total++;
        if (obs() !== pk(1, 4, 2, 0, 0)) begin
            bad++; $display("FAIL full_pushpop: got %h want %h", obs(), pk(1, 4, 2, 0, 0));
        end
        dout_ready = 1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (obs() !== pk(1, vals[i], 2, 0, 0)) begin
                bad++; $display("FAIL full_drain%0d: got %h want %h", i, obs(), pk(1, vals[i], 2, 0, 0));
            end
            cyc(1, 0, 0);
        end
        dout_ready = 0;
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL full_empty: got %b want 0", dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 1); cyc(1, 1, 1);
        cyc(0, 1, 1); cyc(1, 0, 0);
        cyc(0, 1, 5); cyc(0, 1, 5);
        rst = 1; cyc(0, 1, 5); rst = 0;
        total++;
        if (obs() !== pk(0, 0, 0, 0, 0) || dbg_state !== 1'b0) begin
            bad++; $display("FAIL rst_mid: got %h st=%b want %h st=0", obs(), dbg_state, pk(0, 0, 0, 0, 0));
        end
        cyc(0, 1, 3); cyc(1, 1, 3);
        total++;
        if (dout_valid !== 1'b0) begin
            bad++; $display("FAIL rearm_no_frame: got %b want 0", dout_valid);
        end
        cyc(1, 1, 2); cyc(0, 1, 2); cyc(0, 1, 2); cyc(1, 1, 2);
        total++;
        if (obs() !== pk(1, 8, 4, 0, 0)) begin
            bad++; $display("FAIL rearm_frame: got %h want %h", obs(), pk(1, 8, 4, 0, 0));
        end
        dout_ready = 1; cyc(1, 0, 0); dout_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) dec_clk = ~dec_clk;
            din_valid  = ($urandom_range(0, 3) != 0);
            din        = $urandom_range(0, 1) ? DATA_W'($urandom)
                                              : DATA_W'(int'($urandom_range(0, 2000)) - 1000);
            dout_ready = ($urandom_range(0, 2) == 0);
            clear_ovf  = ($urandom_range(0, 15) == 0);
            tick();
            total++;
            if (obs() !== exp_obs()) begin
                bad++; $display("FAIL random_cycle%0d: got %h want %h", i, obs(), exp_obs());
            end
        end
        rst = 0; dout_ready = 0; clear_ovf = 0; din_valid = 0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_edge();
        test_signed_empty();
        test_saturation();
        test_count_sat();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
